// File: rtl/vin_pkg.sv
// Shared constants and types for the DPI RGB-to-grayscale packing path.
package vin_pkg;

    localparam int DEF_LUMA_R     = 77;
    localparam int DEF_LUMA_G     = 150;
    localparam int DEF_LUMA_B     = 29;
    localparam int WORD_W         = 64;
    localparam int PIX_PER_WORD   = 8;
    localparam int PAIRS_PER_WORD = PIX_PER_WORD / 2;
    localparam int ENTRY_W        = WORD_W + 2;
    localparam int LINE_CNT_W     = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2
    } pack_state_t;

    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo_fwft #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 66
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so the output is clean after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/vin_gray_pack.sv
// Converts strobed RGB888 pixel pairs to 8-bit luma and packs eight pixels
// per 64-bit word with frame/line markers into an output FIFO.
module vin_gray_pack
    import vin_pkg::*;
#(
    parameter int OUT_DEPTH = 4,
    parameter int LUMA_R    = DEF_LUMA_R,
    parameter int LUMA_G    = DEF_LUMA_G,
    parameter int LUMA_B    = DEF_LUMA_B
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  v_vsync,
    input  logic                  v_hsync,
    input  logic                  v_pclk,
    input  logic                  v_de,
    input  logic [47:0]           v_pixel,
    output logic [WORD_W-1:0]     m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  overflow,
    output logic [LINE_CNT_W-1:0] line_cnt
);

    localparam logic [8:0] W_R = 9'(LUMA_R);
    localparam logic [8:0] W_G = 9'(LUMA_G);
    localparam logic [8:0] W_B = 9'(LUMA_B);
    localparam logic [LINE_CNT_W-1:0] LINE_MAX = '1;

    function automatic logic [15:0] weight_mul(input logic [7:0] c, input logic [8:0] w);
        return {8'd0, c} * {7'd0, w};
    endfunction

    function automatic logic [7:0] luma_shift(input logic [15:0] r, input logic [15:0] g,
                                              input logic [15:0] b);
        return 8'((r + g + b) >> 8);
    endfunction

    // Line boundaries come from v_de alone, so hsync carries no information here.
    logic unused_hsync;
    assign unused_hsync = v_hsync;

    logic        de_q;
    logic        vs_q;
    logic        accept;
    logic        fall_now;
    logic        vs_rise;

    assign accept   = v_pclk && v_de;
    assign fall_now = de_q && !v_de;
    assign vs_rise  = v_pclk && v_vsync && !vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            de_q <= v_de;
            if (v_pclk) vs_q <= v_vsync;
        end
    end

    // Stage p0: weighted channel products for both pixels
    logic [15:0] prod_p0 [6];
    logic        vld_p0;
    logic        fall_p0;

    always_ff @(posedge clk) begin
        prod_p0[0] <= weight_mul(v_pixel[47:40], W_R);
        prod_p0[1] <= weight_mul(v_pixel[39:32], W_G);
        prod_p0[2] <= weight_mul(v_pixel[31:24], W_B);
        prod_p0[3] <= weight_mul(v_pixel[23:16], W_R);
        prod_p0[4] <= weight_mul(v_pixel[15:8],  W_G);
        prod_p0[5] <= weight_mul(v_pixel[7:0],   W_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            fall_p0 <= 1'b0;
        end else begin
            vld_p0  <= accept;
            fall_p0 <= fall_now && !vs_rise;
        end
    end

    // Stage p1: sum and shift; earlier pixel lands in the low byte
    logic [15:0] luma_p1;
    logic        vld_p1;
    logic        fall_p1;

    always_ff @(posedge clk) begin
        luma_p1 <= {luma_shift(prod_p0[3], prod_p0[4], prod_p0[5]),
                    luma_shift(prod_p0[0], prod_p0[1], prod_p0[2])};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            fall_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0 && !vs_rise;
            fall_p1 <= fall_p0 && !vs_rise;
        end
    end

    // Packer: consumes p1 pairs/falls, produces the p2 push
    pack_state_t       state_q, state_n;
    logic [1:0]        slot_q, slot_n;
    logic [WORD_W-1:0] word_q, word_n;
    logic [WORD_W-1:0] word_ins;
    logic [WORD_W-1:0] word_first;
    logic [WORD_W-1:0] push_word;
    logic              push_req;
    logic              push_eol;
    logic              eol_ahead;
    logic              sof_armed;

    always_comb begin
        word_ins = (slot_q == 2'd0) ? '0 : word_q;
        word_ins[{slot_q, 4'b0000} +: 16] = luma_p1;
        word_first = {48'd0, luma_p1};
        // A fall one or two cycles after the closing strobe marks the completed word as line end.
        eol_ahead = fall_p0 || fall_now;

        state_n   = state_q;
        slot_n    = slot_q;
        word_n    = word_q;
        push_req  = 1'b0;
        push_word = word_ins;
        push_eol  = 1'b0;

        case (state_q)
            IDLE: begin
                if (vld_p1) begin
                    word_n  = word_first;
                    slot_n  = 2'd1;
                    state_n = PACK;
                end
            end
            PACK: begin
                if (vld_p1) begin
                    word_n = word_ins;
                    if (slot_q == 2'(PAIRS_PER_WORD - 1)) begin
                        push_req = 1'b1;
                        push_eol = eol_ahead;
                        slot_n   = 2'd0;
                    end else begin
                        slot_n = slot_q + 2'd1;
                    end
                end else if (fall_p1) begin
                    state_n = (slot_q != 2'd0) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                push_req  = 1'b1;
                push_word = word_q;
                push_eol  = 1'b1;
                slot_n    = 2'd0;
                state_n   = IDLE;
                if (vld_p1) begin
                    word_n  = word_first;
                    slot_n  = 2'd1;
                    state_n = PACK;
                end
            end
            default: state_n = IDLE;
        endcase

        if (vs_rise) begin
            state_n  = IDLE;
            slot_n   = 2'd0;
            push_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            slot_q    <= 2'd0;
            sof_armed <= 1'b0;
        end else begin
            state_q <= state_n;
            slot_q  <= slot_n;
            if (vs_rise)       sof_armed <= 1'b1;
            else if (push_req) sof_armed <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        word_q <= word_n;
    end

    // Stage p2: registered FIFO write
    fifo_entry_t entry_p2;
    logic        push_p2;

    always_ff @(posedge clk) begin
        entry_p2 <= '{sof: sof_armed, eol: push_eol, data: push_word};
    end

    always_ff @(posedge clk) begin
        if (rst) push_p2 <= 1'b0;
        else     push_p2 <= push_req;
    end

    fifo_entry_t head;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;
    assign m_data  = head.data;
    assign m_sof   = head.sof;
    assign m_eol   = head.eol;

    sync_fifo_fwft #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_p2),
        .wr_data (entry_p2),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    logic [LINE_CNT_W-1:0] line_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            line_cnt_q <= '0;
        end else begin
            if (push_p2 && fifo_full && !pop) overflow <= 1'b1;
            if (vs_rise)
                line_cnt_q <= '0;
            else if (fall_now && line_cnt_q != LINE_MAX)
                line_cnt_q <= line_cnt_q + 11'd1;
        end
    end

    assign line_cnt = line_cnt_q;

endmodule

// File: tb/tb_vin_gray_pack.sv
// Randomized scoreboard bench for vin_gray_pack with a pixel-level reference model.
module tb_vin_gray_pack;

    localparam int DEPTH = 4;
    localparam int LR = 77;
    localparam int LG = 150;
    localparam int LB = 29;

    logic        clk;
    logic        rst;
    logic        v_vsync;
    logic        v_hsync;
    logic        v_pclk;
    logic        v_de;
    logic [47:0] v_pixel;
    logic [63:0] m_data;
    logic        m_sof;
    logic        m_eol;
    logic        m_valid;
    logic        m_ready;
    logic        overflow;
    logic [10:0] line_cnt;

    vin_gray_pack #(
        .OUT_DEPTH (DEPTH),
        .LUMA_R    (LR),
        .LUMA_G    (LG),
        .LUMA_B    (LB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .v_vsync  (v_vsync),
        .v_hsync  (v_hsync),
        .v_pclk   (v_pclk),
        .v_de     (v_de),
        .v_pixel  (v_pixel),
        .m_data   (m_data),
        .m_sof    (m_sof),
        .m_eol    (m_eol),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .overflow (overflow),
        .line_cnt (line_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic        sof;
        logic        eol;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pend[$];
    int         checks = 0;
    int         failures = 0;
    int         lines = 0;
    bit         sof_armed = 0;
    bit         hold = 0;
    bit         exp_ovf = 0;
    int         rdy_mode = 1;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_luma(input logic [23:0] p);
        int s;
        s = int'(p[23:16]) * LR + int'(p[15:8]) * LG + int'(p[7:0]) * LB;
        return 8'(s / 256);
    endfunction

    task automatic emit(input bit eol);
        exp_t e;
        e.data = '0;
        foreach (pend[i]) e.data[8*i +: 8] = pend[i];
        pend.delete();
        e.sof = sof_armed;
        e.eol = eol;
        sof_armed = 0;
        if (hold && exp_q.size() >= DEPTH) exp_ovf = 1;
        else exp_q.push_back(e);
    endtask

    task automatic model_pair(input logic [47:0] pix, input bit last);
        pend.push_back(ref_luma(pix[47:24]));
        pend.push_back(ref_luma(pix[23:0]));
        if (pend.size() == 8 || last) emit(last);
    endtask

    // Scoreboard monitor: compares every handshake against the head of the queue.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%0h expected=none", m_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_data", m_data, e.data);
                check("word_sof", 64'(m_sof), 64'(e.sof));
                check("word_eol", 64'(m_eol), 64'(e.eol));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) m_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic drive(input logic pclk, input logic de, input logic vs, input logic [47:0] pix);
        v_pclk  = pclk;
        v_de    = de;
        v_vsync = vs;
        v_hsync = !de && pclk;
        v_pixel = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic send_vsync();
        sof_armed = 1;
        pend.delete();
        lines = 0;
        drive(1, 0, 1, 48'd0);
        drive(0, 0, 1, 48'd0);
        drive(1, 0, 0, 48'd0);
        drive(0, 0, 0, 48'd0);
    endtask

    task automatic send_line(input int n, input bit rnd, input logic [47:0] fixed_pix, input bit pulse);
        logic [47:0] pix;
        int gaps;
        for (int i = 0; i < n; i++) begin
            pix = rnd ? {16'($urandom), 32'($urandom)} : fixed_pix;
            model_pair(pix, i == n - 1);
            drive(1, 1, 0, pix);
            gaps = (i == n - 1) ? 1 : $urandom_range(1, 3);
            repeat (gaps) drive(0, 1, 0, 48'd0);
        end
        lines = (lines < 2047) ? lines + 1 : 2047;
        for (int b = 0; b < 8; b++) begin
            if (pulse && b == 1) m_ready = 1;
            drive((b % 2 == 0) ? 1'b1 : 1'b0, 0, 0, 48'd0);
            if (pulse && b == 1) m_ready = 0;
        end
        check("line_cnt", 64'(line_cnt), 64'(lines));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_data"}, m_data, 64'd0);
        check({tag, "_m_sof"}, 64'(m_sof), 64'd0);
        check({tag, "_m_eol"}, 64'(m_eol), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_line_cnt"}, 64'(line_cnt), 64'd0);
    endtask

    initial begin
        rst = 1;
        m_ready = 0;
        v_vsync = 0;
        v_hsync = 0;
        v_pclk = 0;
        v_de = 0;
        v_pixel = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        check_idle_outputs("reset");

        // White/black pairs after a frame start
        rdy_mode = 0;
        send_vsync();
        send_line(16, 0, {24'hFFFFFF, 24'h000000}, 0);
        wait_drain();

        // Five pairs: one full word plus a flushed partial word
        send_line(5, 0, {24'h102030, 24'h102030}, 0);
        wait_drain();

        // Random frame with random line lengths
        send_vsync();
        for (int l = 0; l < 6; l++) send_line($urandom_range(1, 12), 1, 48'd0, 0);
        wait_drain();

        // Vsync mid-word discards the partial word
        send_vsync();
        for (int i = 0; i < 2; i++) begin
            logic [47:0] pix;
            pix = {16'($urandom), 32'($urandom)};
            model_pair(pix, 0);
            drive(1, 1, 0, pix);
            repeat (3) drive(0, 1, 0, 48'd0);
        end
        send_vsync();
        check("vsync_line_cnt", 64'(line_cnt), 64'd0);
        send_line(4, 1, 48'd0, 0);
        wait_drain();

        // Full FIFO with a pop coinciding with the next push
        rdy_mode = 1;
        m_ready = 0;
        hold = 1;
        send_line(4 * DEPTH, 1, 48'd0, 0);
        check("full_valid", 64'(m_valid), 64'd1);
        hold = 0;
        send_line(4, 1, 48'd0, 1);
        check("full_pop_overflow", 64'(overflow), 64'(exp_ovf));
        rdy_mode = 0;
        wait_drain();

        // Overflow: one word too many while stalled
        rdy_mode = 1;
        m_ready = 0;
        hold = 1;
        send_vsync();
        send_line(4 * (DEPTH + 1), 1, 48'd0, 0);
        check("ovf_valid", 64'(m_valid), 64'd1);
        check("ovf_set", 64'(overflow), 64'(exp_ovf));
        hold = 0;
        m_ready = 1;
        wait_drain();
        check("ovf_sticky", 64'(overflow), 64'(exp_ovf));
        rdy_mode = 0;
        send_line(6, 1, 48'd0, 0);
        wait_drain();

        // Reset in the middle of a word
        for (int i = 0; i < 2; i++) begin
            logic [47:0] pix;
            pix = {16'($urandom), 32'($urandom)};
            drive(1, 1, 0, pix);
            drive(0, 1, 0, 48'd0);
        end
        rst = 1;
        drive(0, 0, 0, 48'd0);
        rst = 0;
        pend.delete();
        sof_armed = 0;
        lines = 0;
        exp_ovf = 0;
        check_idle_outputs("midrst");
        send_line(4, 1, 48'd0, 0);
        wait_drain();
        send_vsync();
        send_line(4, 1, 48'd0, 0);
        wait_drain();

        // Line counter saturation
        send_vsync();
        for (int l = 0; l < 2050; l++) begin
            drive(0, 1, 0, 48'd0);
            drive(0, 0, 0, 48'd0);
            lines = (lines < 2047) ? lines + 1 : 2047;
        end
        check("line_cnt_sat", 64'(line_cnt), 64'(lines));
        send_vsync();
        check("line_cnt_clear", 64'(line_cnt), 64'd0);
        check("final_overflow", 64'(overflow), 64'(exp_ovf));
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
